// File: rtl/hfifo_packer_pkg.sv
// Shared constants and helpers for the hfifo packer and future width converters.
package hfifo_packer_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned TOUT_DEF   = 16;

  // Counter width able to hold 0..n inclusive when n is a power of two.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/hfifo_packer_idle.sv
// Saturating idle timer: counts cycles with a stranded partial word, flags expiry.
module hfifo_packer_idle
  import hfifo_packer_pkg::*;
#(
  parameter int unsigned TOUT   = TOUT_DEF,
  parameter int unsigned TWIDTH = cnt_width(TOUT_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TWIDTH-1:0] r_cnt;
  logic [TWIDTH-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != TWIDTH'(TOUT))) begin
      w_cnt_nxt = r_cnt + TWIDTH'(1);
    end
  end

  // expired mirrors r_cnt == TOUT, kept as its own flop so it is a clean register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      expired <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      expired <= (w_cnt_nxt == TWIDTH'(TOUT));
    end
  end

endmodule

// File: rtl/hfifo_packer.sv
// Packs LANES consecutive hfifo entries into one wide word on a valid/ready port;
// partial words leave on flush or after an idle timeout.
module hfifo_packer
  import hfifo_packer_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned CWIDTH = cnt_width(LANES_DEF),
  parameter int unsigned TOUT   = TOUT_DEF,
  parameter int unsigned TWIDTH = cnt_width(TOUT_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        fifo_dout,
  input  logic                     fifo_rdy,
  output logic                     fifo_pop,
  input  logic                     flush,
  output logic [DWIDTH*LANES-1:0]  out_data,
  output logic [CWIDTH-1:0]        out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned LW = $clog2(LANES);

  logic [DWIDTH-1:0]       r_lane [LANES];
  logic [CWIDTH-1:0]       r_asm_cnt;
  logic                    r_rdy_q;
  logic                    w_idle_exp;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_xfer;
  logic                    w_pop;
  logic                    w_idle_clr;
  logic [DWIDTH*LANES-1:0] w_asm;

  // Pop/transfer decisions use only registered state plus flush/out_ready.
  always_comb begin
    w_empty    = (r_asm_cnt == '0);
    w_full     = (r_asm_cnt == CWIDTH'(LANES));
    w_xfer     = (w_full | (!w_empty & (flush | w_idle_exp))) & (!out_valid | out_ready);
    w_pop      = r_rdy_q & !w_full & !w_xfer;
    w_idle_clr = w_pop | w_xfer | w_empty;
  end

  assign fifo_pop = w_pop;

  // Lanes beyond the assembled count read as zero.
  always_comb begin
    w_asm = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CWIDTH'(i) < r_asm_cnt) begin
        w_asm[i*DWIDTH +: DWIDTH] = r_lane[i];
      end
    end
  end

  hfifo_packer_idle #(
    .TOUT   (TOUT),
    .TWIDTH (TWIDTH)
  ) u_idle (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_idle_clr),
    .inc     (!w_empty),
    .expired (w_idle_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy_q   <= 1'b0;
      r_asm_cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      r_rdy_q <= fifo_rdy;
      if (w_xfer) begin
        r_asm_cnt <= '0;
      end else if (w_pop) begin
        r_lane[r_asm_cnt[LW-1:0]] <= fifo_dout;
        r_asm_cnt                 <= r_asm_cnt + CWIDTH'(1);
      end
    end
  end

  // Output register: a transfer in the accept cycle reloads and keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (w_xfer) begin
      out_data  <= w_asm;
      out_cnt   <= r_asm_cnt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
